grf_mp_score: RTL and testbench

Parametrised multi-port general register file with per-register pending (scoreboard) tracking, for the decode stage of the pipelined CPU. It provides two combinational read ports with optional same-cycle write-to-read bypass and two synchronous write ports. It also keeps a busy bit per register, set at instruction issue and cleared at writeback, so hazard logic can stall on a `rd_ready` flag instead of decoding pipeline registers.

---
 rtl/grf_mp_score.sv | 121 ++++++++++++
 tb/tb_grf_mp_score.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_mp_score.sv
// grf_mp_score: multi-port register file with a per-register pending
// scoreboard for the decode stage.
//   Params : DATA_W (register width), ADDR_W (2^ADDR_W registers, x0 = 0)
//   Clock  : clk, posedge; reset is synchronous, active-high
//   Read   : rd_addr0/1 -> rd_data0/1, rd_ready0/1 (combinational)
//   Write  : wr_en0/1, wr_addr0/1, wr_data0/1 (commit at posedge, port 1 wins)
//   Issue  : iss_en, iss_addr (mark destination pending)
//   Status : pending_cnt (registered count of pending registers)
//   Option : define GRF_BYPASS_EN for same-cycle write-to-read bypass
module grf_mp_score #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_ready0,
   output logic              rd_ready1,
   input  logic              wr_en0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   pending_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   logic w0_v, w1_v, iss_v;
   logic set_v, clr0_v, clr1_v;

   // x0 is never a target: writes and issues to it are dropped here.
   assign w0_v  = wr_en0 && (wr_addr0 != '0);
   assign w1_v  = wr_en1 && (wr_addr1 != '0);
   assign iss_v = iss_en && (iss_addr != '0);

   // Issue is applied after the clears: a newer producer keeps the bit set.
   always_comb begin
      pend_d = pend_q;
      if (w0_v) pend_d[wr_addr0] = 1'b0;
      if (w1_v) pend_d[wr_addr1] = 1'b0;
      if (iss_v) pend_d[iss_addr] = 1'b1;
   end

   // Count actual bit transitions; a register cleared by both ports
   // must only be counted once.
   assign set_v  = iss_v && !pend_q[iss_addr];
   assign clr0_v = w0_v && pend_q[wr_addr0] && !pend_d[wr_addr0];
   assign clr1_v = w1_v && pend_q[wr_addr1] && !pend_d[wr_addr1]
                   && !(w0_v && (wr_addr0 == wr_addr1));

   always_comb begin
      cnt_d = cnt_q
              + {{ADDR_W{1'b0}}, set_v}
              - {{ADDR_W{1'b0}}, clr0_v}
              - {{ADDR_W{1'b0}}, clr1_v};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         if (w0_v) mem_q[wr_addr0] <= wr_data0;
         // Port 1 is the younger writeback; its assignment lands last.
         if (w1_v) mem_q[wr_addr1] <= wr_data1;
      end
   end

   assign pending_cnt = cnt_q;

   always_comb begin
      rd_data0  = mem_q[rd_addr0];
      rd_ready0 = !pend_q[rd_addr0];
`ifdef GRF_BYPASS_EN
      if (w1_v && (wr_addr1 == rd_addr0)) begin
         rd_data0  = wr_data1;
         rd_ready0 = 1'b1;
      end else if (w0_v && (wr_addr0 == rd_addr0)) begin
         rd_data0  = wr_data0;
         rd_ready0 = 1'b1;
      end
`endif
      if (rd_addr0 == '0) begin
         rd_data0  = '0;
         rd_ready0 = 1'b1;
      end
   end

   always_comb begin
      rd_data1  = mem_q[rd_addr1];
      rd_ready1 = !pend_q[rd_addr1];
`ifdef GRF_BYPASS_EN
      if (w1_v && (wr_addr1 == rd_addr1)) begin
         rd_data1  = wr_data1;
         rd_ready1 = 1'b1;
      end else if (w0_v && (wr_addr0 == rd_addr1)) begin
         rd_data1  = wr_data0;
         rd_ready1 = 1'b1;
      end
`endif
      if (rd_addr1 == '0) begin
         rd_data1  = '0;
         rd_ready1 = 1'b1;
      end
   end

endmodule

// File: tb/tb_grf_mp_score.sv
// tb_grf_mp_score: directed and randomized checks of grf_mp_score
// against a behavioural register-file/scoreboard model.
module tb_grf_mp_score;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int N  = 1 << AW;

   logic          clk, reset;
   logic [AW-1:0] rd_addr0, rd_addr1;
   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_ready0, rd_ready1;
   logic          wr_en0, wr_en1;
   logic [AW-1:0] wr_addr0, wr_addr1;
   logic [DW-1:0] wr_data0, wr_data1;
   logic          iss_en;
   logic [AW-1:0] iss_addr;
   logic [AW:0]   pending_cnt;

   grf_mp_score #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(rd_data0), .rd_data1(rd_data1),
      .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
      .wr_en0(wr_en0), .wr_en1(wr_en1),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
      .wr_data0(wr_data0), .wr_data1(wr_data1),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .pending_cnt(pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arrays updated by the architectural rules.
   logic [DW-1:0] m_mem [N];
   bit            m_pend [N];
   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int popc();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic logic [DW:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return {1'b1, {DW{1'b0}}};
`ifdef GRF_BYPASS_EN
      if (wr_en1 && wr_addr1 == a) return {1'b1, wr_data1};
      if (wr_en0 && wr_addr0 == a) return {1'b1, wr_data0};
`endif
      return {!m_pend[a], m_mem[a]};
   endfunction

   task automatic model_clock();
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (wr_en0 && wr_addr0 != 0) begin
            m_mem[wr_addr0]  = wr_data0;
            m_pend[wr_addr0] = 1'b0;
         end
         if (wr_en1 && wr_addr1 != 0) begin
            m_mem[wr_addr1]  = wr_data1;
            m_pend[wr_addr1] = 1'b0;
         end
         if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      end
   endtask

   task automatic check_reads();
      logic [DW:0] e0, e1;
      e0 = exp_rd(rd_addr0);
      e1 = exp_rd(rd_addr1);
      check("rd_data0", rd_data0, e0[DW-1:0]);
      check("rd_ready0", rd_ready0, e0[DW]);
      check("rd_data1", rd_data1, e1[DW-1:0]);
      check("rd_ready1", rd_ready1, e1[DW]);
   endtask

   // Inputs are set just after a posedge; reads are checked before the
   // next edge, the model advances on it, and the count is checked after.
   task automatic tick();
      #1 check_reads();
      @(posedge clk);
      model_clock();
      #1 check("pending_cnt", pending_cnt, (AW+1)'(popc()));
   endtask

   task automatic idle();
      reset  = 1'b0;
      wr_en0 = 1'b0; wr_en1 = 1'b0;
      iss_en = 1'b0;
   endtask

   task automatic wr0(input int a, input logic [DW-1:0] d);
      wr_en0 = 1'b1; wr_addr0 = AW'(a); wr_data0 = d;
   endtask

   task automatic wr1(input int a, input logic [DW-1:0] d);
      wr_en1 = 1'b1; wr_addr1 = AW'(a); wr_data1 = d;
   endtask

   task automatic iss(input int a);
      iss_en = 1'b1; iss_addr = AW'(a);
   endtask

   task automatic rd_sweep_zero(input string tag);
      for (int i = 0; i < N; i++) begin
         rd_addr0 = AW'(i);
         rd_addr1 = AW'(N - 1 - i);
         #1;
         check({tag, "_d0"}, rd_data0, 0);
         check({tag, "_r0"}, rd_ready0, 1);
         check({tag, "_d1"}, rd_data1, 0);
         check({tag, "_r1"}, rd_ready1, 1);
      end
      check({tag, "_cnt"}, pending_cnt, 0);
   endtask

   initial begin
      idle();
      rd_addr0 = '0; rd_addr1 = '0;
      wr_addr0 = '0; wr_addr1 = '0;
      wr_data0 = '0; wr_data1 = '0;
      iss_addr = '0;
      for (int i = 0; i < N; i++) begin
         m_mem[i] = '0; m_pend[i] = 1'b0;
      end
      @(posedge clk);
      #1 reset = 1'b1;
      tick();
      idle();
      rd_sweep_zero("reset");

      // Write x5 on port 0, same-cycle then next-cycle read.
      @(posedge clk); #1;
      wr0(5, 32'h1234); rd_addr0 = 5;
      #1;
`ifdef GRF_BYPASS_EN
      check("byp_x5_data", rd_data0, 32'h1234);
      check("byp_x5_ready", rd_ready0, 1);
`else
      check("nobyp_x5_data", rd_data0, 0);
`endif
      tick();
      idle();
      #1 check("x5_next", rd_data0, 32'h1234);

      // Both ports to x7, then both ports to x0.
      wr0(7, 32'hAAAA); wr1(7, 32'hBBBB);
      tick();
      idle(); rd_addr0 = 7;
      #1 check("x7_p1_wins", rd_data0, 32'hBBBB);
      wr0(0, 32'hDEAD); wr1(0, 32'hBEEF); rd_addr1 = 0;
      tick();
      idle();
      #1 check("x0_zero", rd_data1, 0);
      check("x0_ready", rd_ready1, 1);

      // Issue x3, write it back, then issue+write together.
      iss(3); rd_addr0 = 3;
      tick();
      idle();
      check("iss_x3_cnt", pending_cnt, 1);
      #1 check("iss_x3_ready", rd_ready0, 0);
      wr0(3, 32'h55);
      tick();
      idle();
      check("wb_x3_cnt", pending_cnt, 0);
      #1 check("wb_x3_data", rd_data0, 32'h55);
      check("wb_x3_ready", rd_ready0, 1);
      iss(3); wr1(3, 32'h66);
      tick();
      idle();
      check("coll_x3_cnt", pending_cnt, 1);
      #1 check("coll_x3_ready", rd_ready0, 0);
      wr0(3, 32'h77);
      tick();
      idle();

      // Successive issues, dual writeback, issue of x0.
      iss(1); tick();
      iss(2); tick();
      iss(3); tick();
      idle();
      check("iss3_cnt", pending_cnt, 3);
      wr0(1, 32'h11); wr1(2, 32'h22);
      tick();
      idle();
      check("dual_wb_cnt", pending_cnt, 1);
      iss(0);
      tick();
      idle();
      check("iss_x0_cnt", pending_cnt, 1);

      // Reset with four registers pending and concurrent strobes.
      wr0(10, 32'hA0); wr1(11, 32'hB0); tick();
      wr0(12, 32'hC0); iss(10); tick();
      idle(); iss(11); tick();
      iss(12); tick();
      idle();
      check("pre_reset_cnt", pending_cnt, 4);
      reset = 1'b1; wr0(13, 32'hD0); iss(13);
      tick();
      idle();
      rd_sweep_zero("midreset");

      // Randomized traffic on a narrow address range to force collisions.
      for (int k = 0; k < 3000; k++) begin
         reset    = ($urandom_range(0, 99) == 0);
         wr_en0   = $urandom_range(0, 1) == 1;
         wr_en1   = $urandom_range(0, 1) == 1;
         iss_en   = $urandom_range(0, 1) == 1;
         wr_addr0 = AW'($urandom_range(0, 7));
         wr_addr1 = AW'($urandom_range(0, 7));
         iss_addr = AW'($urandom_range(0, 1) == 1 ?
                        $urandom_range(0, 7) : $urandom_range(0, N - 1));
         wr_data0 = $urandom;
         wr_data1 = $urandom;
         rd_addr0 = AW'($urandom_range(0, 7));
         rd_addr1 = AW'($urandom_range(0, N - 1));
         tick();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
